pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter START_PC, default 64'h0, PC value loaded on reset.
REQ-002 Parameter COUNT_W, default 32, width of the cycle and retired-instruction counters.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 resetl  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  holds PC and state when high.
REQ-006 halt_req  input  1  requests a permanent stop after the current instruction retires.
REQ-007 branch_uncond  input  1  current instruction is B.
REQ-008 branch_cond  input  1  current instruction is CBZ.
REQ-009 zero  input  1  ALU zero flag for the current instruction.
REQ-010 br_offset  input  64  sign-extended word offset from the decoded immediate (imm26 or imm19).
REQ-011 instr_in  input  32  instruction word returned by instruction memory for pc_out.
REQ-012 pc_out  output  64  current PC; drives the instruction memory Address.
REQ-013 instr_out  output  32  instruction passed to decode; equals instr_in when fetch_valid is high, else 32'h0.
REQ-014 fetch_valid  output  1  instr_out is a real instruction this cycle.
REQ-015 halted  output  1  unit is in HALT.
REQ-016 cycle_count  output  COUNT_W  cycles spent in RUN or STALL since reset.
REQ-017 retired_count  output  COUNT_W  instructions retired since reset.

Function
REQ-018 The state machine has states BOOT, RUN, STALL and HALT.
REQ-019 BOOT lasts exactly one cycle after reset release, with fetch_valid=0 and the PC held, then goes to RUN.
REQ-020 In RUN with stall=0, fetch_valid=1, the instruction retires at the clock edge, and the PC loads next_pc.
REQ-021 next_pc is PC+(br_offset<<2) when branch_uncond=1, or when branch_cond=1 and zero=1; otherwise PC+4.
REQ-022 All next_pc arithmetic is 64-bit modulo 2^64; wrap-around is silent, with no flag.
REQ-023 branch_uncond takes priority over branch_cond; both high behaves as B.
REQ-024 stall=1 in RUN: go to STALL, PC unchanged, fetch_valid=0, retired_count unchanged.
REQ-025 STALL returns to RUN on the first cycle with stall=0; instr_in at the held PC is then re-presented.
REQ-026 halt_req=1 in RUN with stall=0: the current instruction retires, the PC updates, then the unit enters HALT.
REQ-027 halt_req=1 in STALL is registered and takes effect on the first retiring cycle.
REQ-028 halt_req=1 with stall=1 in the same RUN cycle: stall wins; the halt is pending per REQ-027.
REQ-029 HALT is absorbing until reset: PC frozen, fetch_valid=0, counters frozen, halted=1.
REQ-030 cycle_count increments in RUN and STALL.
REQ-031 retired_count increments on each retiring RUN edge.
REQ-032 Both counters saturate at all-ones.
REQ-033 instr_in is consumed combinationally (single-cycle datapath); there is no instruction register.

Reset
REQ-034 On resetl=0, the following apply immediately, independent of CLK: PC=START_PC, state=BOOT, fetch_valid=0, halted=0, both counters=0, pending halt cleared.
REQ-035 Reset asserted mid-operation, including in STALL or HALT, discards all state per REQ-034.
REQ-036 Reset release is synchronised; the first active edge after release performs the BOOT step.

Structure
REQ-037 Shared package fetch_pkg holds the state enumeration, PC width (64), instruction width (32) and the default START_PC.
REQ-038 One sub-module, next_pc_logic, holds the purely combinational next_pc computation of REQ-021 to REQ-023.
REQ-039 pc_fetch_unit holds the PC register, state machine, halt latch and counters.

Verification
REQ-040 Reset release with START_PC=0, no branches, stall=0: pc_out sequence 0x0, 0x0 (BOOT), 0x4, 0x8; fetch_valid sequence 0, 1, 1.
REQ-041 PC=0x20, branch_cond=1, zero=0 -> next pc_out=0x24. Same with zero=1 and br_offset=4 -> next pc_out=0x30.
REQ-042 PC=0x2c, instr 0x17FFFFFD, branch_uncond=1, br_offset=-3 -> next pc_out=0x20. Running the counted-loop program to STUR at 0x30 yields the exact retired_count expected from the loop.
REQ-043 stall high for 3 cycles at PC=0x10 -> pc_out stays 0x10 and fetch_valid=0 for those cycles; cycle_count +3, retired_count +0.
REQ-044 Apply halt_req with stall=1, then drop stall -> one retirement, then halted=1 with PC and counters frozen for 10 cycles. Reset pulse -> PC=START_PC.
REQ-045 PC=64'hFFFF_FFFF_FFFF_FFFC, no branch -> next pc_out=0x0. Counter preset near max -> saturates at all-ones.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : fetch_pkg                                               |
// | Purpose    : Shared widths, reset PC and state encoding for the      |
// |              instruction fetch unit.                                 |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
package fetch_pkg;

  localparam int              PC_W             = 64;
  localparam int              INSTR_W          = 32;
  localparam logic [PC_W-1:0] DEFAULT_START_PC = 64'h0;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/next_pc_logic.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : next_pc_logic                                           |
// | Purpose    : Combinational next-PC selection: sequential PC+4 or     |
// |              PC-relative branch target (word offset << 2).           |
// | Ports      : pc_i            current PC                              |
// |              branch_uncond_i B instruction                           |
// |              branch_cond_i   CBZ instruction                         |
// |              zero_i          ALU zero flag                           |
// |              br_offset_i     sign-extended word offset               |
// |              next_pc_o       PC for the next retiring edge           |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module next_pc_logic
  import fetch_pkg::*;
(
  input  logic [PC_W-1:0] pc_i,
  input  logic            branch_uncond_i,
  input  logic            branch_cond_i,
  input  logic            zero_i,
  input  logic [PC_W-1:0] br_offset_i,
  output logic [PC_W-1:0] next_pc_o
);

  logic            w_taken;
  logic [PC_W-1:0] w_offset_bytes;

  // B wins over CBZ, but both use the same offset, so an OR of the two
  // conditions already gives the B behaviour when both are high.
  assign w_taken        = branch_uncond_i | (branch_cond_i & zero_i);
  assign w_offset_bytes = br_offset_i << 2;

  // Modulo-2^64 add; carry out is intentionally dropped.
  assign next_pc_o = pc_i + (w_taken ? w_offset_bytes : 64'd4);

endmodule : next_pc_logic
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : pc_fetch_unit                                           |
// | Purpose    : PC register, BOOT/RUN/STALL/HALT sequencer, pending     |
// |              halt latch and saturating cycle / retire counters.      |
// | Ports      : CLK, resetl (async, active-low)                         |
// |              stall, halt_req, branch_uncond, branch_cond, zero,      |
// |              br_offset, instr_in                     (inputs)        |
// |              pc_out, instr_out, fetch_valid, halted,                 |
// |              cycle_count, retired_count              (outputs)       |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] START_PC = DEFAULT_START_PC,
  parameter int              COUNT_W  = 32
) (
  input  logic               CLK,
  input  logic               resetl,
  input  logic               stall,
  input  logic               halt_req,
  input  logic               branch_uncond,
  input  logic               branch_cond,
  input  logic               zero,
  input  logic [PC_W-1:0]    br_offset,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               fetch_valid,
  output logic               halted,
  output logic [COUNT_W-1:0] cycle_count,
  output logic [COUNT_W-1:0] retired_count
);

  localparam logic [COUNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] c_CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  fetch_state_e       state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_d;
  logic               halt_pend_q;
  logic               halted_q;
  logic [COUNT_W-1:0] cycle_cnt_q;
  logic [COUNT_W-1:0] cycle_cnt_d;
  logic [COUNT_W-1:0] retired_cnt_q;
  logic [COUNT_W-1:0] retired_cnt_d;
  logic               w_retire;

  next_pc_logic u_next_pc (
    .pc_i            (pc_q),
    .branch_uncond_i (branch_uncond),
    .branch_cond_i   (branch_cond),
    .zero_i          (zero),
    .br_offset_i     (br_offset),
    .next_pc_o       (pc_d)
  );

  // Only RUN retires; the cycle leaving STALL is a bubble, after which
  // the instruction at the held PC is presented again in RUN.
  assign w_retire = (state_q == ST_RUN) & ~stall;

  assign cycle_cnt_d   = (cycle_cnt_q   == c_CNT_MAX) ? cycle_cnt_q   : cycle_cnt_q   + c_CNT_ONE;
  assign retired_cnt_d = (retired_cnt_q == c_CNT_MAX) ? retired_cnt_q : retired_cnt_q + c_CNT_ONE;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q       <= ST_BOOT;
      pc_q          <= START_PC;
      halt_pend_q   <= 1'b0;
      halted_q      <= 1'b0;
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          cycle_cnt_q <= cycle_cnt_d;
          if (stall) begin
            // Stall wins over a simultaneous halt request; keep it pending.
            state_q <= ST_STALL;
            if (halt_req) halt_pend_q <= 1'b1;
          end else begin
            pc_q          <= pc_d;
            retired_cnt_q <= retired_cnt_d;
            if (halt_req || halt_pend_q) begin
              state_q     <= ST_HALT;
              halted_q    <= 1'b1;
              halt_pend_q <= 1'b0;
            end
          end
        end
        ST_STALL: begin
          cycle_cnt_q <= cycle_cnt_d;
          if (halt_req) halt_pend_q <= 1'b1;
          if (!stall)   state_q     <= ST_RUN;
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_BOOT;
        end
      endcase
    end
  end

  assign pc_out        = pc_q;
  assign fetch_valid   = w_retire;
  assign instr_out     = w_retire ? instr_in : '0;
  assign halted        = halted_q;
  assign cycle_count   = cycle_cnt_q;
  assign retired_count = retired_cnt_q;

endmodule : pc_fetch_unit
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_pc_fetch_unit                                        |
// | Purpose    : Self-checking bench for pc_fetch_unit with an           |
// |              instruction-level reference model and a small counted   |
// |              loop program.                                           |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module tb_pc_fetch_unit;

  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          resetl = 1'b1;
  logic          stall = 1'b0;
  logic          halt_req = 1'b0;
  logic          branch_uncond = 1'b0;
  logic          branch_cond = 1'b0;
  logic          zero = 1'b0;
  logic [63:0]   br_offset = '0;
  logic [31:0]   instr_in = '0;
  logic [63:0]   pc_out;
  logic [31:0]   instr_out;
  logic          fetch_valid;
  logic          halted;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] retired_count;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural view of the fetch unit.
  logic [63:0] m_pc;
  bit          m_boot, m_stalled, m_halted, m_pend;
  int          m_cyc, m_ret;

  pc_fetch_unit #(.START_PC(64'h0), .COUNT_W(CW)) dut (
    .CLK           (CLK),
    .resetl        (resetl),
    .stall         (stall),
    .halt_req      (halt_req),
    .branch_uncond (branch_uncond),
    .branch_cond   (branch_cond),
    .zero          (zero),
    .br_offset     (br_offset),
    .instr_in      (instr_in),
    .pc_out        (pc_out),
    .instr_out     (instr_out),
    .fetch_valid   (fetch_valid),
    .halted        (halted),
    .cycle_count   (cycle_count),
    .retired_count (retired_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic bit exp_fv();
    return !m_boot && !m_stalled && !m_halted && !stall;
  endfunction

  task automatic clear_inputs();
    stall = 0; halt_req = 0; branch_uncond = 0; branch_cond = 0; zero = 0;
    br_offset = '0; instr_in = $urandom;
  endtask

  // Advance the model by one clock using the inputs currently applied,
  // then move to the next falling edge.
  task automatic tick();
    bit retire;
    logic [63:0] tgt;
    retire = exp_fv();
    tgt = (branch_uncond || (branch_cond && zero)) ? m_pc + br_offset * 64'd4 : m_pc + 64'd4;
    @(posedge CLK);
    if (!m_halted) begin
      if (m_boot) m_boot = 0;
      else begin
        m_cyc = sat(m_cyc + 1);
        if (retire) begin
          m_ret = sat(m_ret + 1);
          m_pc  = tgt;
          if (halt_req || m_pend) begin m_halted = 1; m_pend = 0; end
        end else begin
          if (halt_req) m_pend = 1;
          m_stalled = stall;
        end
      end
    end
    @(negedge CLK);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    clear_inputs();
    resetl = 0;
    #1;
    m_pc = 64'h0; m_boot = 1; m_stalled = 0; m_halted = 0; m_pend = 0; m_cyc = 0; m_ret = 0;
    checks++; if (pc_out !== 64'h0) begin errors++; $display("FAIL rst_pc got %h want 0", pc_out); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_fv got %b want 0", fetch_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
    checks++; if (cycle_count !== '0 || retired_count !== '0) begin
      errors++; $display("FAIL rst_counts got %0d/%0d want 0/0", cycle_count, retired_count);
    end
    @(posedge CLK);
    @(negedge CLK);
    resetl = 1;
  endtask

  // Reach a target PC from RUN with one unconditional branch.
  task automatic goto_pc(input logic [63:0] target);
    clear_inputs();
    branch_uncond = 1;
    br_offset = $signed(target - m_pc) >>> 2;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_boot();
    do_reset();
    #1;
    checks++; if (pc_out !== 64'h0 || fetch_valid !== 1'b0) begin
      errors++; $display("FAIL boot pc=%h fv=%b want 0/0", pc_out, fetch_valid);
    end
    tick();
    checks++; if (pc_out !== 64'h0 || fetch_valid !== 1'b1) begin
      errors++; $display("FAIL run0 pc=%h fv=%b want 0/1", pc_out, fetch_valid);
    end
    tick();
    checks++; if (pc_out !== 64'h4 || fetch_valid !== 1'b1) begin
      errors++; $display("FAIL run1 pc=%h fv=%b want 4/1", pc_out, fetch_valid);
    end
    tick();
    checks++; if (pc_out !== 64'h8) begin errors++; $display("FAIL run2 pc=%h want 8", pc_out); end
  endtask

  task automatic test_branches();
    do_reset(); tick();
    goto_pc(64'h20);
    branch_cond = 1; zero = 0; br_offset = 64'd4; tick(); clear_inputs();
    checks++; if (pc_out !== 64'h24) begin errors++; $display("FAIL cbz_nt pc=%h want 24", pc_out); end
    goto_pc(64'h20);
    branch_cond = 1; zero = 1; br_offset = 64'd4; tick(); clear_inputs();
    checks++; if (pc_out !== 64'h30) begin errors++; $display("FAIL cbz_t pc=%h want 30", pc_out); end
    // Both branch kinds with zero=0: behaves as B.
    branch_uncond = 1; branch_cond = 1; zero = 0; br_offset = 64'd2; tick(); clear_inputs();
    checks++; if (pc_out !== 64'h38) begin errors++; $display("FAIL b_prio pc=%h want 38", pc_out); end
  endtask

  // Counted loop: setup at 0x00-0x1c, SUB X1 at 0x20, CBZ X1,+3 at 0x24,
  // filler at 0x28, B -3 at 0x2c, STUR at 0x30.
  task automatic test_loop_program();
    logic [31:0] mem [0:12];
    logic [31:0] w;
    logic [63:0] pc_prev;
    bit          ret_now;
    int          n, x1, exp_ret;
    for (int i = 0; i < 8; i++) mem[i] = 32'h8B1F03E0 + i;
    mem[8] = 32'hD1000421; mem[9] = 32'hB4000061; mem[10] = 32'h8B020063;
    mem[11] = 32'h17FFFFFD; mem[12] = 32'hF8000041;
    n = $urandom_range(2, 5);
    x1 = n;
    exp_ret = 8 + 4 * (n - 1) + 2;
    do_reset(); tick();
    for (int cyc = 0; cyc < 300 && m_pc != 64'h30; cyc++) begin
      clear_inputs();
      w = mem[m_pc[5:2]];
      instr_in = w;
      if (w[31:26] == 6'b000101) begin
        branch_uncond = 1; br_offset = {{38{w[25]}}, w[25:0]};
      end else if (w[31:24] == 8'hB4) begin
        branch_cond = 1; br_offset = {{45{w[23]}}, w[23:5]}; zero = (x1 == 0);
      end
      stall = ($urandom_range(0, 3) == 0);
      #1;
      checks++; if (pc_out !== m_pc || fetch_valid !== exp_fv()) begin
        errors++; $display("FAIL loop_step pc=%h fv=%b want %h/%b", pc_out, fetch_valid, m_pc, exp_fv());
      end
      ret_now = exp_fv();
      pc_prev = m_pc;
      tick();
      if (ret_now && pc_prev == 64'h20) x1--;
      if (ret_now && pc_prev == 64'h2c) begin
        checks++; if (pc_out !== 64'h20) begin errors++; $display("FAIL b_back pc=%h want 20", pc_out); end
      end
    end
    clear_inputs();
    #1;
    checks++; if (pc_out !== 64'h30 || retired_count !== CW'(exp_ret)) begin
      errors++; $display("FAIL loop_end pc=%h ret=%0d want 30/%0d", pc_out, retired_count, exp_ret);
    end
  endtask

  task automatic test_stall();
    int c0, r0;
    do_reset(); tick();
    repeat (4) tick();
    c0 = m_cyc; r0 = m_ret;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (pc_out !== 64'h10 || fetch_valid !== 1'b0) begin
        errors++; $display("FAIL stall_hold pc=%h fv=%b want 10/0", pc_out, fetch_valid);
      end
      tick();
    end
    checks++; if (cycle_count !== CW'(c0 + 3) || retired_count !== CW'(r0)) begin
      errors++; $display("FAIL stall_cnt got %0d/%0d want %0d/%0d", cycle_count, retired_count, c0 + 3, r0);
    end
    stall = 0;
    tick();
    #1;
    checks++; if (pc_out !== 64'h10 || fetch_valid !== 1'b1) begin
      errors++; $display("FAIL stall_resume pc=%h fv=%b want 10/1", pc_out, fetch_valid);
    end
    tick();
  endtask

  task automatic test_halt();
    int c0, r0;
    r0 = m_ret;
    stall = 1; halt_req = 1; tick();
    halt_req = 0; stall = 0; tick();
    #1;
    checks++; if (halted !== 1'b0 || fetch_valid !== 1'b1) begin
      errors++; $display("FAIL halt_pre h=%b fv=%b want 0/1", halted, fetch_valid);
    end
    tick();
    c0 = m_cyc;
    checks++; if (halted !== 1'b1 || retired_count !== CW'(r0 + 1) || pc_out !== 64'h18) begin
      errors++; $display("FAIL halt_entry h=%b ret=%0d pc=%h want 1/%0d/18", halted, retired_count, pc_out, r0 + 1);
    end
    for (int i = 0; i < 10; i++) begin
      branch_uncond = 1'($urandom); br_offset = 64'($urandom); halt_req = 1'($urandom);
      #1;
      checks++; if (pc_out !== 64'h18 || fetch_valid !== 1'b0 || halted !== 1'b1 ||
                    cycle_count !== CW'(c0) || retired_count !== CW'(r0 + 1)) begin
        errors++; $display("FAIL halt_frozen pc=%h fv=%b h=%b cyc=%0d ret=%0d", pc_out, fetch_valid, halted, cycle_count, retired_count);
      end
      tick();
    end
    do_reset();
  endtask

  task automatic test_wrap_and_saturation();
    do_reset(); tick();
    branch_uncond = 1; br_offset = '1; tick(); clear_inputs();
    checks++; if (pc_out !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_neg pc=%h want fffffffffffffffc", pc_out); end
    tick();
    checks++; if (pc_out !== 64'h0) begin errors++; $display("FAIL wrap_zero pc=%h want 0", pc_out); end
    repeat (70) tick();
    checks++; if (cycle_count !== CW'(CMAX) || retired_count !== CW'(CMAX)) begin
      errors++; $display("FAIL saturate got %0d/%0d want %0d/%0d", cycle_count, retired_count, CMAX, CMAX);
    end
  endtask

  task automatic test_random();
    do_reset(); tick();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      stall         = ($urandom_range(0, 3) == 0);
      halt_req      = ($urandom_range(0, 39) == 0);
      branch_uncond = ($urandom_range(0, 7) == 0);
      branch_cond   = ($urandom_range(0, 5) == 0);
      zero          = 1'($urandom);
      br_offset     = $urandom_range(0, 1) ? 64'($signed(6'($urandom))) : {32'($urandom), 32'($urandom)};
      instr_in      = $urandom;
      #1;
      checks++; if (pc_out !== m_pc || fetch_valid !== exp_fv() || halted !== m_halted ||
                    instr_out !== (exp_fv() ? instr_in : 32'h0) ||
                    cycle_count !== CW'(m_cyc) || retired_count !== CW'(m_ret)) begin
        errors++;
        $display("FAIL rand_step pc=%h fv=%b h=%b io=%h cyc=%0d ret=%0d want %h/%b/%b/%0d/%0d",
                 pc_out, fetch_valid, halted, instr_out, cycle_count, retired_count,
                 m_pc, exp_fv(), m_halted, m_cyc, m_ret);
      end
      tick();
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset_boot();
    test_branches();
    test_loop_program();
    test_stall();
    test_halt();
    test_wrap_and_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pc_fetch_unit
`default_nettype wire
